// File: rtl/decode_rename_pipe_reg.sv
// Decode -> rename pipeline register with a one-bundle skid buffer.
// OUT drives the rename stage; SKID catches a bundle that arrives while
// OUT is stalled, and its occupancy is reported back as pauseReq.
module decode_rename_pipe_reg #(
  parameter int unsigned UOP_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             flush,
  output logic             pauseReq,
  input  logic             dec0_valid,
  input  logic             dec1_valid,
  input  logic [UOP_W-1:0] dec0_uop,
  input  logic [UOP_W-1:0] dec1_uop,
  output logic             ren0_valid,
  output logic             ren1_valid,
  output logic [UOP_W-1:0] ren0_uop,
  output logic [UOP_W-1:0] ren1_uop,
  input  logic             ren_ready,
  input  logic             rob_ready
);

  typedef struct packed {
    logic             v0;
    logic             v1;
    logic [UOP_W-1:0] u0;
    logic [UOP_W-1:0] u1;
  } bundle_t;

  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  bundle_t in_b;
  logic    pause_req_q, pause_req_d;
  logic    out_occ, skid_occ, in_occ, adv, sample;

  assign in_b     = '{v0: dec0_valid, v1: dec1_valid, u0: dec0_uop, u1: dec1_uop};
  assign out_occ  = out_q.v0 | out_q.v1;
  assign skid_occ = skid_q.v0 | skid_q.v1;
  assign in_occ   = dec0_valid | dec1_valid;
  assign adv      = ren_ready & rob_ready & ~pause;
  assign sample   = ~pause & ~pause_req_q;

  // Next-state for both stages: flush, then pause, then skid drain, then input load.
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (flush) begin
      out_d.v0  = 1'b0;
      out_d.v1  = 1'b0;
      skid_d.v0 = 1'b0;
      skid_d.v1 = 1'b0;
    end else if (pause) begin
      out_d  = out_q;
      skid_d = skid_q;
    end else if (skid_occ) begin
      if (adv) begin
        out_d     = skid_q;
        skid_d.v0 = 1'b0;
        skid_d.v1 = 1'b0;
      end
    end else if (sample) begin
      // An empty input bundle loaded into OUT simply leaves OUT empty.
      if (!out_occ || adv) begin
        out_d = in_b;
      end else if (in_occ) begin
        skid_d = in_b;
      end
    end
    pause_req_d = skid_d.v0 | skid_d.v1;
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q       <= '0;
      skid_q      <= '0;
      pause_req_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      pause_req_q <= pause_req_d;
    end
  end

  assign pauseReq   = pause_req_q;
  assign ren0_valid = out_q.v0;
  assign ren1_valid = out_q.v1;
  assign ren0_uop   = out_q.u0;
  assign ren1_uop   = out_q.u1;

endmodule

// File: tb/tb_decode_rename_pipe_reg.sv
// Bench for decode_rename_pipe_reg: directed scenarios plus random traffic,
// checked against a queue-of-bundles reference model.
module tb_decode_rename_pipe_reg;
  localparam int unsigned W = 128;

  logic         clk = 1'b0;
  logic         rst, pause, flush, pauseReq;
  logic         dec0_valid, dec1_valid, ren0_valid, ren1_valid;
  logic         ren_ready, rob_ready;
  logic [W-1:0] dec0_uop, dec1_uop, ren0_uop, ren1_uop;

  always #5 clk = ~clk;

  decode_rename_pipe_reg #(.UOP_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pause      (pause),
    .flush      (flush),
    .pauseReq   (pauseReq),
    .dec0_valid (dec0_valid),
    .dec1_valid (dec1_valid),
    .dec0_uop   (dec0_uop),
    .dec1_uop   (dec1_uop),
    .ren0_valid (ren0_valid),
    .ren1_valid (ren1_valid),
    .ren0_uop   (ren0_uop),
    .ren1_uop   (ren1_uop),
    .ren_ready  (ren_ready),
    .rob_ready  (rob_ready)
  );

  typedef struct packed {
    logic         v0;
    logic         v1;
    logic [W-1:0] u0;
    logic [W-1:0] u1;
  } bundle_t;

  // Model: ordered list of bundles held by the block (front is on ren*).
  bundle_t mq[$];
  bundle_t model_log[$];
  bundle_t dut_log[$];
  bundle_t sent[$];
  int compared   = 0;
  int mismatched = 0;

  function automatic bundle_t mk(input logic v0, input logic v1,
                                 input logic [W-1:0] u0, input logic [W-1:0] u1);
    bundle_t b;
    b.v0 = v0; b.v1 = v1; b.u0 = u0; b.u1 = u1;
    return b;
  endfunction

  function automatic logic [W-1:0] rnd_uop();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    bundle_t e;
    e = '0;
    if (mq.size() > 0) e = mq[0];
    chk({tag, ".ren0_valid"}, W'(ren0_valid), W'(e.v0));
    chk({tag, ".ren1_valid"}, W'(ren1_valid), W'(e.v1));
    chk({tag, ".pauseReq"}, W'(pauseReq), W'(mq.size() == 2));
    if (e.v0) chk({tag, ".ren0_uop"}, ren0_uop, e.u0);
    if (e.v1) chk({tag, ".ren1_uop"}, ren1_uop, e.u1);
  endtask

  task automatic drive(input logic v0, input logic v1,
                       input logic [W-1:0] u0, input logic [W-1:0] u1);
    dec0_valid = v0; dec1_valid = v1; dec0_uop = u0; dec1_uop = u1;
  endtask

  // One clock: log handshakes, advance the model, then check outputs.
  task automatic cycle(input string tag);
    bit adv, samp;
    adv  = ren_ready & rob_ready & ~pause;
    samp = !pause && (mq.size() < 2);
    if (rst && !flush && adv && (ren0_valid | ren1_valid))
      dut_log.push_back(mk(ren0_valid, ren1_valid, ren0_uop, ren1_uop));
    @(posedge clk);
    if (!rst || flush) begin
      mq.delete();
    end else if (!pause) begin
      if (mq.size() > 0 && adv) model_log.push_back(mq.pop_front());
      if (samp && (dec0_valid | dec1_valid))
        mq.push_back(mk(dec0_valid, dec1_valid, dec0_uop, dec1_uop));
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] hold0, hold1;
    int           i, cyc;

    rst = 1'b0; pause = 1'b0; flush = 1'b0;
    ren_ready = 1'b1; rob_ready = 1'b1;
    drive(1'b1, 1'b1, rnd_uop(), rnd_uop());
    @(negedge clk);
    cycle("reset0");
    cycle("reset1");
    chk("reset.ren0_uop", ren0_uop, '0);
    chk("reset.ren1_uop", ren1_uop, '0);
    chk("reset.pauseReq", W'(pauseReq), '0);

    // Basic one-cycle latency.
    rst = 1'b1;
    drive(1'b1, 1'b1, W'(8'h11), W'(8'h22));
    cycle("basic");
    chk("basic.ren0_uop", ren0_uop, W'(8'h11));
    chk("basic.ren1_uop", ren1_uop, W'(8'h22));
    chk("basic.valids", W'({ren0_valid, ren1_valid}), W'(2'b11));
    chk("basic.pauseReq", W'(pauseReq), '0);

    // Stall with rename not ready: B goes to the skid.
    ren_ready = 1'b0;
    drive(1'b1, 1'b1, W'(8'h44), W'(8'h55));
    cycle("skid");
    chk("skid.pauseReq", W'(pauseReq), W'(1'b1));
    chk("skid.ren0_uop", ren0_uop, W'(8'h11));
    drive(1'b0, 1'b0, rnd_uop(), rnd_uop());
    ren_ready = 1'b1;
    cycle("skid_drain");
    chk("skid_drain.ren0_uop", ren0_uop, W'(8'h44));
    chk("skid_drain.ren1_uop", ren1_uop, W'(8'h55));
    chk("skid_drain.pauseReq", W'(pauseReq), '0);
    cycle("empty");

    // Flush beats pause with both stages full.
    ren_ready = 1'b0;
    drive(1'b1, 1'b1, rnd_uop(), rnd_uop());
    cycle("fill_a");
    drive(1'b1, 1'b0, rnd_uop(), rnd_uop());
    cycle("fill_b");
    flush = 1'b1; pause = 1'b1;
    cycle("flush");
    chk("flush.valids", W'({ren0_valid, ren1_valid, pauseReq}), '0);
    flush = 1'b0; pause = 1'b0;

    // Pause freezes everything while decode toggles.
    drive(1'b1, 1'b1, rnd_uop(), rnd_uop());
    cycle("pfill_a");
    drive(1'b0, 1'b1, rnd_uop(), rnd_uop());
    cycle("pfill_b");
    hold0 = ren0_uop; hold1 = ren1_uop;
    pause = 1'b1; ren_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'($urandom), 1'($urandom), rnd_uop(), rnd_uop());
      cycle("pause");
      chk("pause.ren0_uop", ren0_uop, hold0);
      chk("pause.ren1_uop", ren1_uop, hold1);
      chk("pause.pauseReq", W'(pauseReq), W'(1'b1));
    end
    pause = 1'b0;
    drive(1'b0, 1'b0, rnd_uop(), rnd_uop());
    cycle("pdrain0");
    cycle("pdrain1");

    // Slot 1 only: no compaction.
    drive(1'b0, 1'b1, rnd_uop(), W'(8'h33));
    cycle("slot1");
    chk("slot1.ren0_valid", W'(ren0_valid), '0);
    chk("slot1.ren1_valid", W'(ren1_valid), W'(1'b1));
    chk("slot1.ren1_uop", ren1_uop, W'(8'h33));
    drive(1'b0, 1'b0, rnd_uop(), rnd_uop());
    cycle("slot1_drain");

    // Ten-bundle stream with random rob_ready: order preserved, no loss.
    dut_log.delete();
    sent.delete();
    i = 0; cyc = 0;
    while (i < 10 && cyc < 200) begin
      bundle_t b;
      b = mk(1'b1, 1'($urandom), rnd_uop(), rnd_uop());
      if ($urandom_range(1, 0) == 1) begin b.v0 = 1'b0; b.v1 = 1'b1; end
      drive(b.v0, b.v1, b.u0, b.u1);
      rob_ready = 1'($urandom);
      if (mq.size() < 2) begin sent.push_back(b); i++; end
      cycle("stream");
      cyc++;
    end
    drive(1'b0, 1'b0, rnd_uop(), rnd_uop());
    rob_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle("stream_drain");
    chk("stream.count", W'(dut_log.size()), W'(10));
    for (int k = 0; k < 10; k++) begin
      if (k < dut_log.size()) begin
        chk("stream.order_u0", dut_log[k].u0 & {W{sent[k].v0}}, sent[k].u0 & {W{sent[k].v0}});
        chk("stream.order_u1", dut_log[k].u1 & {W{sent[k].v1}}, sent[k].u1 & {W{sent[k].v1}});
        chk("stream.order_v", W'({dut_log[k].v0, dut_log[k].v1}), W'({sent[k].v0, sent[k].v1}));
      end
    end

    // Reset mid-stream discards pending bundles; next input accepted.
    ren_ready = 1'b0;
    drive(1'b1, 1'b1, rnd_uop(), rnd_uop());
    cycle("rfill_a");
    cycle("rfill_b");
    rst = 1'b0;
    cycle("midreset");
    rst = 1'b1; ren_ready = 1'b1;
    drive(1'b1, 1'b0, W'(8'h77), rnd_uop());
    cycle("after_reset");
    chk("after_reset.ren0_uop", ren0_uop, W'(8'h77));

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom), 1'($urandom), rnd_uop(), rnd_uop());
      pause     = ($urandom_range(4, 0) == 0);
      flush     = ($urandom_range(24, 0) == 0);
      rst       = ($urandom_range(49, 0) != 0);
      ren_ready = ($urandom_range(3, 0) != 0);
      rob_ready = ($urandom_range(3, 0) != 0);
      cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/decode_rename_pipe_reg.md
DECODE_RENAME_PIPE_REG -- requirements
Module: decode_rename_pipe_reg

Interface
REQ-001 SHALL have parameter UOP_W, default 128, width of one decoded micro-op bundle (opaque payload).
REQ-002 SHALL have port clk, input, 1 bit, single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port pause, input, 1 bit, global pipeline freeze from Ctrl.
REQ-005 SHALL have port flush, input, 1 bit, pipeline kill from Ctrl.
REQ-006 SHALL have port pauseReq, output, 1 bit, stall request to Ctrl/decode, registered.
REQ-007 SHALL have ports dec0_valid and dec1_valid, input, 1 bit each, slot-0/slot-1 valid from decode.
REQ-008 SHALL have ports dec0_uop and dec1_uop, input, UOP_W bits each, slot payloads from decode.
REQ-009 SHALL have ports ren0_valid and ren1_valid, output, 1 bit each, slot valids to rename.
REQ-010 SHALL have ports ren0_uop and ren1_uop, output, UOP_W bits each, slot payloads to rename.
REQ-011 SHALL have port ren_ready, input, 1 bit, rename can allocate (free list not exhausted).
REQ-012 SHALL have port rob_ready, input, 1 bit, Dispatch_ROB side has room for two entries.

Function
REQ-013 SHALL hold two bundle stages: OUT (drives ren*) and SKID; each stage stores both slot valids and payloads; a stage is occupied when either slot valid is 1.
REQ-014 SHALL define adv = ren_ready & rob_ready & ~pause; a cycle with OUT occupied and adv=1 consumes OUT.
REQ-015 SHALL define in_occ = dec0_valid | dec1_valid; input is sampled only when pause=0 and pauseReq=0.
REQ-016 SHALL, when SKID is occupied and adv=1, move SKID into OUT and clear SKID; input is ignored that cycle.
REQ-017 SHALL, when SKID is empty and (OUT empty or adv=1) and input is sampled, load input into OUT; if in_occ=0, OUT becomes empty.
REQ-018 SHALL, when SKID is empty, OUT is occupied, adv=0, input sampled and in_occ=1, load input into SKID and keep OUT unchanged.
REQ-019 SHALL keep both stages unchanged whenever pause=1.
REQ-020 SHALL drive pauseReq equal to the registered SKID-occupied flag; pauseReq is 0 in the cycle after reset.
REQ-021 SHALL give flush priority over pause and all data movement: on a flush edge, all four valids clear; payloads do not matter.
REQ-022 SHALL preserve slot order: slot 0 always leaves on ren0 and slot 1 on ren1; no compaction when only slot 1 is valid.
REQ-023 SHALL never drop or duplicate a bundle: every sampled occupied bundle appears on ren* for exactly one adv cycle, unless flushed.
REQ-024 SHALL have a latency of one cycle: an input bundle sampled with OUT empty or adv=1 appears on ren* the next cycle.
REQ-025 SHALL drive ren*_uop directly from OUT registers; ren*_valid SHALL NOT depend combinationally on ren_ready/rob_ready.

Reset
REQ-026 SHALL, on a clock edge with rst=0, clear OUT and SKID valids and pauseReq; payload registers reset to 0.
REQ-027 SHALL treat reset mid-stream like flush: pending bundles are discarded, and the first sampled bundle after rst returns to 1 is accepted normally.

Verification
REQ-028 Reset then dec0/dec1 valid with uops 0x11/0x22, ren_ready=rob_ready=1 -> next cycle ren0_valid=ren1_valid=1, ren0_uop=0x11, ren1_uop=0x22, pauseReq=0.
REQ-029 OUT holds A, ren_ready=0, input B sampled -> B in SKID, pauseReq=1 next cycle, ren* still A; ren_ready=1 -> ren*=B next cycle, pauseReq=0.
REQ-030 OUT=A, SKID=B, flush=1 with pause=1 -> next cycle all ren valids 0, pauseReq=0.
REQ-031 pause=1 for 3 cycles while dec* toggles with new uops -> ren* and pauseReq unchanged for those cycles.
REQ-032 dec0_valid=0, dec1_valid=1 with uop 0x33 -> ren0_valid=0, ren1_valid=1, ren1_uop=0x33.
REQ-033 Stream of 10 consecutive bundles with rob_ready toggled randomly -> output sequence equals input sequence, no loss or duplication.
